mips_cpu_bus_master: RTL
========================

// Module: mips_cpu_bus_master
// PURPOSE
//  Parametrised Avalon-MM master that arbitrates fetch and data channels of the MIPS core onto one bus.
//  Handles waitrequest stalls, byte-lane steering, sub-word sign/zero extension, misalignment and timeout.
//  Sits between the core FSM and the top-level Avalon ports; one bus transaction outstanding at a time.
// PARAMETERS
//  ADDR_WIDTH      32   byte address width
//  DATA_WIDTH      32   bus data width, 32 or 64; BE_WIDTH = DATA_WIDTH/8, OFS = log2(BE_WIDTH)
//  TIMEOUT_CYCLES  256  max consecutive waitrequest cycles before abort; 0 disables timeout
// PORTS
//  clk          in   1           clock, rising edge
//  reset        in   1           asynchronous, active-low reset
//  i_req        in   1           fetch request (word-sized read), sampled in IDLE
//  i_addr       in   ADDR_WIDTH  fetch address
//  i_done       out  1           1-cycle pulse: fetch finished
//  i_rdata      out  32          fetched instruction, valid while i_done=1
//  d_req        in   1           data request, sampled in IDLE
//  d_we         in   1           1=store, 0=load
//  d_size       in   2           0=1B 1=2B 2=4B 3=8B (8B legal only if DATA_WIDTH=64)
//  d_signed     in   1           load sign-extends when 1, zero-extends when 0
//  d_addr       in   ADDR_WIDTH  data byte address
//  d_wdata      in   DATA_WIDTH  store data, right-justified (LSBs)
//  d_done       out  1           1-cycle pulse: data op finished (incl. error)
//  d_rdata      out  DATA_WIDTH  extended load result, valid while d_done=1
//  err          out  1           valid with i_done/d_done: 1=misaligned or timeout
//  busy         out  1           1 whenever state != IDLE
//  address/write/read/writedata/byteenable  out  Avalon master; readdata, waitrequest  in
// BEHAVIOUR
//  Reset (reset=0, async): state=IDLE; read=write=0; byteenable=0; address=writedata=0;
//   i_done=d_done=err=busy=0; i_rdata=d_rdata=0; timeout counter=0. Deassertion sync to clk.
//  FSM: IDLE -> BUS -> DONE -> IDLE. All outputs registered.
//  IDLE: if d_req, accept data op (data wins ties); else if i_req, accept fetch.
//   Misaligned (addr mod size-bytes != 0, or size>OFS): skip BUS, go to DONE with err=1, no bus cycle.
//   Fetch misaligned if i_addr[1:0]!=0.
//  BUS: address = {addr[AW-1:OFS], OFS'b0}; read/write held, address/writedata/byteenable stable
//   every cycle waitrequest=1. Completes in the cycle read|write=1 and waitrequest=0;
//   readdata captured that cycle. Next cycle read=write=0, state=DONE.
//  Byte lanes (little-endian): offset k=addr[OFS-1:0]; byteenable = ((1<<2^size)-1) << k;
//   writedata = d_wdata << 8k; load = (readdata >> 8k) masked to size, then sign/zero extended.
//   Fetch: byteenable all-ones for the 32-bit lane selected by addr[OFS-1:2].
//  Timeout: counter increments each BUS cycle with waitrequest=1, clears on entry to BUS.
//   Reaching TIMEOUT_CYCLES: drop read/write next cycle, go to DONE with err=1.
//  DONE: exactly one of i_done/d_done pulses 1 cycle; err/rdata valid only this cycle; -> IDLE.
//  Requests must be held until done; requests arriving outside IDLE are ignored until IDLE.
//  Latency: req in IDLE cycle N -> read/write asserted N+1 -> done at (completion cycle)+1; min 3 cycles.
//  Async reset mid-BUS: read/write drop immediately, transaction abandoned, no done pulse.
// TESTING
//  1. Reset=0 mid-read with waitrequest=1 -> read=0, busy=0 same cycle; no done after release.
//  2. LW 0x1000, waitrequest 3 cycles, readdata=0xDEADBEEF -> address stable 4 cycles, d_rdata=0xDEADBEEF.
//  3. LB signed addr 0x1003, readdata=0x80FFFFFF -> byteenable=4'b1000, d_rdata=0xFFFFFF80; LBU -> 0x00000080.
//  4. SH addr 0x2002, d_wdata=0x1234 -> byteenable=4'b1100, writedata[31:16]=0x1234, write 1 cycle.
//  5. i_req and d_req same cycle -> data served first, fetch issued after d_done; LW 0x2001 -> err=1, no bus.
//  6. TIMEOUT_CYCLES=8, waitrequest stuck 1 -> read drops after 8 stall cycles, d_done=1, err=1.

Source files
------------

// File: rtl/mips_cpu_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : mips_cpu_bus_master
// Brief   : Avalon-MM master arbitrating MIPS fetch/data channels onto one bus
// Rev     : 1.0  initial release
// ============================================================================
module mips_cpu_bus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_req,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_done,
  output logic [31:0]             i_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [1:0]              d_size,
  input  logic                    d_signed,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_done,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    err,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   address,
  output logic                    write,
  output logic                    read,
  output logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   readdata,
  input  logic                    waitrequest
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OFS      = $clog2(BE_WIDTH);
  localparam int c_tcnt_w = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tcnt_w:0] c_tlimit = (c_tcnt_w + 1)'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_is_data, w_is_data_nxt;
  logic [1:0]            r_size, w_size_nxt;
  logic                  r_signed, w_signed_nxt;
  logic [OFS-1:0]        r_ofs, w_ofs_nxt;
  logic [c_tcnt_w-1:0]   r_tcnt, w_tcnt_nxt;

  logic [ADDR_WIDTH-1:0] w_address_nxt;
  logic                  w_read_nxt, w_write_nxt;
  logic [DATA_WIDTH-1:0] w_writedata_nxt;
  logic [BE_WIDTH-1:0]   w_be_nxt;
  logic                  w_i_done_nxt, w_d_done_nxt, w_err_nxt, w_busy_nxt;
  logic [31:0]           w_i_rdata_nxt;
  logic [DATA_WIDTH-1:0] w_d_rdata_nxt;

  // A fetch is treated as an unsigned word load from i_addr.
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [1:0]            w_req_size;
  logic [2:0]            w_low_mask;
  logic                  w_misaligned;
  logic [BE_WIDTH-1:0]   w_req_be;
  logic [DATA_WIDTH-1:0] w_req_wdata;
  logic [DATA_WIDTH-1:0] w_rd_shifted, w_load_ext;
  logic                  w_load_sign;

  function automatic logic [BE_WIDTH-1:0] size_lanes(input logic [1:0] size);
    logic [BE_WIDTH-1:0] lanes;
    for (int i = 0; i < BE_WIDTH; i++) lanes[i] = (i < (1 << size));
    return lanes;
  endfunction

  assign w_req_addr  = d_req ? d_addr : i_addr;
  assign w_req_size  = d_req ? d_size : 2'd2;
  assign w_req_be    = size_lanes(w_req_size) << w_req_addr[OFS-1:0];
  assign w_req_wdata = d_wdata << {w_req_addr[OFS-1:0], 3'b000};

  always_comb begin
    w_low_mask = 3'b000;
    case (w_req_size)
      2'd1:    w_low_mask = 3'b001;
      2'd2:    w_low_mask = 3'b011;
      2'd3:    w_low_mask = 3'b111;
      default: w_low_mask = 3'b000;
    endcase
    w_misaligned = (int'(w_req_size) > OFS) || ((w_req_addr[2:0] & w_low_mask) != 3'b000);
  end

  assign w_rd_shifted = readdata >> {r_ofs, 3'b000};

  always_comb begin
    w_load_sign = 1'b0;
    if (r_signed) begin
      case (r_size)
        2'd0:    w_load_sign = w_rd_shifted[7];
        2'd1:    w_load_sign = w_rd_shifted[15];
        2'd2:    w_load_sign = w_rd_shifted[31];
        default: w_load_sign = w_rd_shifted[DATA_WIDTH-1];
      endcase
    end
    for (int i = 0; i < DATA_WIDTH; i++)
      w_load_ext[i] = (i < (8 << r_size)) ? w_rd_shifted[i] : w_load_sign;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_is_data_nxt   = r_is_data;
    w_size_nxt      = r_size;
    w_signed_nxt    = r_signed;
    w_ofs_nxt       = r_ofs;
    w_tcnt_nxt      = r_tcnt;
    w_address_nxt   = address;
    w_read_nxt      = read;
    w_write_nxt     = write;
    w_writedata_nxt = writedata;
    w_be_nxt        = byteenable;
    w_i_done_nxt    = 1'b0;
    w_d_done_nxt    = 1'b0;
    w_err_nxt       = 1'b0;
    w_i_rdata_nxt   = '0;
    w_d_rdata_nxt   = '0;
    case (r_state)
      S_IDLE: begin
        if (d_req || i_req) begin
          w_is_data_nxt = d_req;
          w_size_nxt    = w_req_size;
          w_signed_nxt  = d_req & d_signed;
          w_ofs_nxt     = w_req_addr[OFS-1:0];
          if (w_misaligned) begin
            w_state_nxt  = S_DONE;
            w_i_done_nxt = ~d_req;
            w_d_done_nxt = d_req;
            w_err_nxt    = 1'b1;
          end else begin
            w_state_nxt   = S_BUS;
            w_tcnt_nxt    = '0;
            w_address_nxt = {w_req_addr[ADDR_WIDTH-1:OFS], {OFS{1'b0}}};
            w_read_nxt    = ~(d_req & d_we);
            w_write_nxt   = d_req & d_we;
            w_be_nxt      = w_req_be;
            if (d_req && d_we) w_writedata_nxt = w_req_wdata;
          end
        end
      end
      S_BUS: begin
        if (!waitrequest) begin
          w_state_nxt  = S_DONE;
          w_read_nxt   = 1'b0;
          w_write_nxt  = 1'b0;
          w_i_done_nxt = ~r_is_data;
          w_d_done_nxt = r_is_data;
          if (r_is_data) begin
            if (read) w_d_rdata_nxt = w_load_ext;
          end else begin
            w_i_rdata_nxt = w_rd_shifted[31:0];
          end
        end else if (TIMEOUT_CYCLES != 0 && ({1'b0, r_tcnt} + 1'b1) == c_tlimit) begin
          w_state_nxt  = S_DONE;
          w_read_nxt   = 1'b0;
          w_write_nxt  = 1'b0;
          w_i_done_nxt = ~r_is_data;
          w_d_done_nxt = r_is_data;
          w_err_nxt    = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_is_data  <= 1'b0;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_ofs      <= '0;
      r_tcnt     <= '0;
      address    <= '0;
      read       <= 1'b0;
      write      <= 1'b0;
      writedata  <= '0;
      byteenable <= '0;
      i_done     <= 1'b0;
      d_done     <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_is_data  <= w_is_data_nxt;
      r_size     <= w_size_nxt;
      r_signed   <= w_signed_nxt;
      r_ofs      <= w_ofs_nxt;
      r_tcnt     <= w_tcnt_nxt;
      address    <= w_address_nxt;
      read       <= w_read_nxt;
      write      <= w_write_nxt;
      writedata  <= w_writedata_nxt;
      byteenable <= w_be_nxt;
      i_done     <= w_i_done_nxt;
      d_done     <= w_d_done_nxt;
      err        <= w_err_nxt;
      busy       <= w_busy_nxt;
      i_rdata    <= w_i_rdata_nxt;
      d_rdata    <= w_d_rdata_nxt;
    end
  end
endmodule
`default_nettype wire
